tstate_gen: RTL and testbench

//  Parametrised T-state (ring counter) generator for the SAP-1 control sequencer.

---
 rtl/sap_pkg.sv | 24 ++
 rtl/onehot_enc.sv | 31 +++
 rtl/tstate_gen.sv | 89 ++++++++
 tb/tb_tstate_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants and helpers for the SAP-1 control sequencer.
package sap_pkg;

  localparam int unsigned NSTATES_DEF = 6;
  localparam int unsigned NSTATES_MAX = 16;

  localparam logic [NSTATES_MAX-1:0] T_IDLE = '0;

  // Width needed to hold a binary T-state index 0..n.
  function automatic int unsigned idxw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // One-hot word for Tk (k = 1..NSTATES_MAX); k = 0 gives IDLE.
  function automatic logic [NSTATES_MAX-1:0] onehot(input int unsigned k);
    logic [NSTATES_MAX-1:0] v;
    v = T_IDLE;
    if (k >= 1 && k <= NSTATES_MAX) begin
      v = NSTATES_MAX'(1) << (k - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary index encoder with multi-hot detection.
module onehot_enc
  import sap_pkg::*;
#(
  parameter int unsigned N = NSTATES_DEF,
  parameter int unsigned W = idxw(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         multi_o
);

  logic [W-1:0] cnt_c;
  logic [W-1:0] idx_c;

  // Count set bits and remember the index of the highest one.
  always_comb begin
    cnt_c = '0;
    idx_c = '0;
    for (int k = 0; k < N; k++) begin
      if (vec_i[k]) begin
        cnt_c = cnt_c + W'(1);
        idx_c = W'(k + 1);
      end
    end
  end

  assign multi_o = (cnt_c > W'(1));
  assign idx_o   = multi_o ? '0 : idx_c;

endmodule

// File: rtl/tstate_gen.sv
// T-state ring counter for the SAP-1 sequencer; steps on falling CLK so the
// control word settles before the datapath's rising edge.
module tstate_gen
  import sap_pkg::*;
#(
  parameter int unsigned NSTATES = NSTATES_DEF,
  parameter int unsigned IDXW    = idxw(NSTATES)
) (
  input  logic               CLK,
  input  logic               nCLR,
  input  logic               EN,
  input  logic               HLT,
  input  logic [IDXW-1:0]    LEN,
  input  logic               END_I,
  output logic [NSTATES-1:0] state,
  output logic [IDXW-1:0]    tidx,
  output logic               first,
  output logic               wrap,
  output logic               err
);

  localparam logic [NSTATES_MAX-1:0] T1_FULL = onehot(1);
  localparam logic [NSTATES-1:0]     T1      = T1_FULL[NSTATES-1:0];
  localparam logic [IDXW-1:0]        L_MAX   = IDXW'(NSTATES);

  logic [NSTATES-1:0] state_q, state_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic [IDXW-1:0]    idx_c;
  logic               multi_c;
  logic [IDXW-1:0]    len_eff_c;

  onehot_enc #(
    .N (NSTATES),
    .W (IDXW)
  ) u_enc (
    .vec_i   (state_q),
    .idx_o   (idx_c),
    .multi_o (multi_c)
  );

  // Zero or out-of-range length means the full ring.
  assign len_eff_c = (LEN == '0 || LEN > L_MAX) ? L_MAX : LEN;

  // Next state: halt > recovery > hold > end/wrap > advance.
  always_comb begin
    state_d = state_q;
    wrap_d  = wrap_q;
    err_d   = err_q;
    if (HLT) begin
      state_d = state_q;
    end else if (multi_c) begin
      state_d = '0;
      wrap_d  = 1'b0;
      err_d   = 1'b1;
    end else if (!EN) begin
      state_d = state_q;
    end else if (state_q == '0) begin
      state_d = T1;
      wrap_d  = 1'b0;
    end else if (END_I || idx_c >= len_eff_c) begin
      state_d = T1;
      wrap_d  = 1'b1;
    end else begin
      state_d = state_q << 1;
      wrap_d  = 1'b0;
    end
  end

  // State registers, falling-edge clocked with async clear.
  always_ff @(negedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign tidx  = idx_c;
  assign first = (state_q == T1);
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_tstate_gen.sv
// Scoreboard bench for tstate_gen (NSTATES=6 main instance, NSTATES=2 corner).
module tb_tstate_gen;

  logic       CLK;
  logic       nCLR;
  logic       EN, HLT, END_I;
  logic [2:0] LEN;
  logic [5:0] state;
  logic [2:0] tidx;
  logic       first, wrap, err;

  logic       EN2, HLT2, END2;
  logic [1:0] LEN2;
  logic [1:0] state2;
  logic [1:0] tidx2;
  logic       first2, wrap2, err2;

  typedef struct packed {
    logic [5:0] st;
    logic [2:0] idx;
    logic       legal;
    logic       fst;
    logic       wrp;
    logic       er;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  int         m_k;
  logic       m_wrap;
  logic       m_err;
  logic [5:0] m_vec;

  tstate_gen #(.NSTATES(6)) dut (
    .CLK(CLK), .nCLR(nCLR), .EN(EN), .HLT(HLT), .LEN(LEN), .END_I(END_I),
    .state(state), .tidx(tidx), .first(first), .wrap(wrap), .err(err)
  );

  tstate_gen #(.NSTATES(2)) dut2 (
    .CLK(CLK), .nCLR(nCLR), .EN(EN2), .HLT(HLT2), .LEN(LEN2), .END_I(END2),
    .state(state2), .tidx(tidx2), .first(first2), .wrap(wrap2), .err(err2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.legal = (m_k >= 0);
    if (m_k < 0)       e.st = m_vec;
    else if (m_k == 0) e.st = 6'b0;
    else               e.st = 6'(1 << (m_k - 1));
    e.idx = (m_k > 0) ? 3'(m_k) : 3'd0;
    e.fst = (m_k == 1);
    e.wrp = m_wrap;
    e.er  = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_k = 0; m_wrap = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic hlt, input logic endi, input logic [2:0] len);
    int l;
    if (hlt) begin
    end else if (m_k < 0) begin
      m_k = 0; m_wrap = 1'b0; m_err = 1'b1;
    end else if (!en) begin
    end else if (m_k == 0) begin
      m_k = 1; m_wrap = 1'b0;
    end else begin
      l = (len == 3'd0 || len > 3'd6) ? 6 : int'(len);
      if (endi || m_k >= l) begin
        m_k = 1; m_wrap = 1'b1;
      end else begin
        m_k = m_k + 1; m_wrap = 1'b0;
      end
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_state"}, 32'(state), 32'(e.st));
    if (e.legal) chk({tag, "_tidx"}, 32'(tidx), 32'(e.idx));
    chk({tag, "_first"}, 32'(first), 32'(e.fst));
    chk({tag, "_wrap"}, 32'(wrap), 32'(e.wrp));
    chk({tag, "_err"}, 32'(err), 32'(e.er));
  endtask

  task automatic check_now(input string tag);
    sb_q.push_back(model_exp());
    compare_out(tag);
  endtask

  // Drive one falling edge worth of inputs, predict, then compare after the edge.
  task automatic step(input string tag, input logic en, input logic hlt, input logic endi,
                      input logic [2:0] len);
    EN = en; HLT = hlt; END_I = endi; LEN = len;
    model_step(en, hlt, endi, len);
    sb_q.push_back(model_exp());
    @(negedge CLK);
    #1;
    compare_out(tag);
  endtask

  task automatic do_reset(input string tag);
    nCLR = 1'b0;
    model_reset();
    #2;
    check_now(tag);
    #2;
    nCLR = 1'b1;
  endtask

  logic [1:0] e2_st   [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
  logic       e2_wrap [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    n_checks = 0; n_fail = 0;
    EN = 1'b0; HLT = 1'b0; END_I = 1'b0; LEN = 3'd0;
    EN2 = 1'b0; HLT2 = 1'b0; END2 = 1'b0; LEN2 = 2'd0;
    m_vec = 6'b0;
    model_reset();
    nCLR = 1'b1;
    #2 nCLR = 1'b0;
    #3;
    check_now("rst");
    EN = 1'b1;
    @(negedge CLK);
    #1;
    check_now("rst_hold");
    nCLR = 1'b1;

    repeat (7) step("ring6", 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (8) step("len4", 1'b1, 1'b0, 1'b0, 3'd4);

    step("to_t2", 1'b1, 1'b0, 1'b0, 3'd0);
    step("end_i", 1'b1, 1'b0, 1'b1, 3'd0);
    step("after_end", 1'b1, 1'b0, 1'b0, 3'd0);

    step("to_t3", 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (5) step("hlt", 1'b1, 1'b1, 1'b1, 3'd0);
    step("hlt_rel", 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (3) step("en0", 1'b0, 1'b0, 1'b1, 3'd0);
    step("to_t5", 1'b1, 1'b0, 1'b0, 3'd0);

    step("len_drop", 1'b1, 1'b0, 1'b0, 3'd3);
    repeat (2) step("hlt_wrap", 1'b1, 1'b1, 1'b0, 3'd0);
    repeat (7) step("len7", 1'b1, 1'b0, 1'b0, 3'd7);

    repeat (3) step("to_t5b", 1'b1, 1'b0, 1'b0, 3'd0);
    do_reset("mid_rst");
    step("rst_rel", 1'b1, 1'b0, 1'b0, 3'd0);

    step("pre_dep", 1'b1, 1'b0, 1'b0, 3'd0);
    dut.state_q = 6'b000101;
    m_k = -1;
    m_vec = 6'b000101;
    #1;
    check_now("dep");
    step("dep_hlt", 1'b1, 1'b1, 1'b0, 3'd0);
    step("recover", 1'b0, 1'b0, 1'b0, 3'd0);
    step("post_rec", 1'b1, 1'b0, 1'b0, 3'd0);
    step("post_rec2", 1'b1, 1'b0, 1'b0, 3'd0);
    do_reset("err_clr");

    EN = 1'b0;
    EN2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      LEN2 = (i >= 4) ? 2'd1 : 2'd0;
      @(negedge CLK);
      #1;
      chk("n2_state", 32'(state2), 32'(e2_st[i]));
      chk("n2_tidx", 32'(tidx2), (e2_st[i] == 2'b01) ? 32'd1 : 32'd2);
      chk("n2_first", 32'(first2), 32'(e2_st[i] == 2'b01));
      chk("n2_wrap", 32'(wrap2), 32'(e2_wrap[i]));
      chk("n2_err", 32'(err2), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
